// File: rtl/axi_dma_ram_pkg.sv
// Shared encodings for the AXI DMA RAM responder: response codes, burst types
// and the write/read channel state enums.
package axi_dma_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

endpackage

// File: rtl/sp_ram_64.sv
// Single-port DEPTH x 64 SRAM with byte write enables and a registered read.
// The read register only updates on a read access, so it holds across writes.
module sp_ram_64 #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [7:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 8; b++) begin
                    if (be_i[b]) begin
                        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_dma_ram.sv
// AXI4 64-bit responder over a single-port byte-writable SRAM. Independent
// write and read FSMs share the SRAM port through an alternating-priority arbiter.
module axi_dma_ram
    import axi_dma_ram_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 1,
    parameter int unsigned DEPTH    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Ready outputs stay low until the first clock after reset release.
    logic rdy_en_q;
    logic prio_rd_q, prio_rd_d;
    logic w_req, r_req, w_gnt, r_gnt;

    wr_state_e           w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [AW-1:0]       w_idx_q, w_idx_d;
    logic [7:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic                w_fixed_q, w_fixed_d, w_err_q, w_err_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                w_last_beat, w_bad_last;

    rd_state_e           r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [AW-1:0]       r_idx_q, r_idx_d;
    logic [7:0]          r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic                r_fixed_q, r_fixed_d, r_done_q, r_done_d;
    logic                rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic                r_last_issue;

    logic [63:0]         ram_rdata;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{i_awaddr[2:0], i_awaddr[31:AW+3],
                                i_araddr[2:0], i_araddr[31:AW+3]};

    assign w_req = (w_state_q == W_DATA) & i_wvalid;
    assign r_req = (r_state_q == R_BURST) & ~r_done_q & (~rvalid_q | i_rready);
    assign w_gnt = w_req & (~r_req | ~prio_rd_q);
    assign r_gnt = r_req & (~w_req | prio_rd_q);
    assign prio_rd_d = (w_req & r_req) ? ~prio_rd_q : prio_rd_q;

    assign w_last_beat  = (w_cnt_q == w_len_q);
    assign w_bad_last   = (i_wlast != w_last_beat);
    assign r_last_issue = (r_cnt_q == r_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                o_awready = rdy_en_q;
                if (i_awvalid && rdy_en_q) begin
                    w_id_d    = i_awid;
                    w_idx_d   = i_awaddr[AW+2:3];
                    w_len_d   = i_awlen;
                    w_fixed_d = (i_awburst == BURST_FIXED);
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                o_wready = w_gnt;
                if (w_gnt) begin
                    w_err_d = w_err_q | w_bad_last;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (!w_fixed_q) begin
                        w_idx_d = w_idx_q + AW'(1);
                    end
                    if (w_last_beat) begin
                        bresp_d   = (w_err_q | w_bad_last) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        r_done_d  = r_done_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        o_arready = 1'b0;
        // A granted issue lands in the R slot next cycle; otherwise a taken beat empties it.
        if (r_gnt) begin
            rvalid_d = 1'b1;
            rlast_d  = r_last_issue;
        end else if (i_rready) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
        unique case (r_state_q)
            R_IDLE: begin
                o_arready = rdy_en_q;
                if (i_arvalid && rdy_en_q) begin
                    r_id_d    = i_arid;
                    r_idx_d   = i_araddr[AW+2:3];
                    r_len_d   = i_arlen;
                    r_fixed_d = (i_arburst == BURST_FIXED);
                    r_cnt_d   = '0;
                    r_done_d  = 1'b0;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_gnt) begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (!r_fixed_q) begin
                        r_idx_d = r_idx_q + AW'(1);
                    end
                    if (r_last_issue) begin
                        r_done_d = 1'b1;
                    end
                end
                if (rvalid_q && i_rready && rlast_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q  <= 1'b0;
            prio_rd_q <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            rdy_en_q  <= 1'b1;
            prio_rd_q <= prio_rd_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_done_q  <= r_done_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    sp_ram_64 #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .en_i   (w_gnt | r_gnt),
        .we_i   (w_gnt),
        .be_i   (i_wstrb),
        .addr_i (w_gnt ? w_idx_q : r_idx_q),
        .wdata_i(i_wdata),
        .rdata_o(ram_rdata)
    );

    assign o_bid    = w_id_q;
    assign o_bresp  = bresp_q;
    assign o_rid    = r_id_q;
    assign o_rresp  = RESP_OKAY;
    assign o_rvalid = rvalid_q;
    assign o_rlast  = rlast_q;
    assign o_rdata  = rvalid_q ? ram_rdata : 64'h0;

endmodule

// File: tb/tb_axi_dma_ram.sv
// Self-checking bench for axi_dma_ram: a word-array memory model with expected
// B/R queues, checked every cycle from a negedge monitor, plus directed literals.
module tb_axi_dma_ram;
    import axi_dma_ram_pkg::*;

    localparam int IDW   = 2;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IDW-1:0]  i_awid = '0, i_arid = '0;
    logic [31:0]     i_awaddr = '0, i_araddr = '0;
    logic [7:0]      i_awlen = '0, i_arlen = '0;
    logic [1:0]      i_awburst = '0, i_arburst = '0;
    logic            i_awvalid = 1'b0, i_arvalid = 1'b0;
    logic [63:0]     i_wdata = '0;
    logic [7:0]      i_wstrb = '0;
    logic            i_wlast = 1'b0, i_wvalid = 1'b0;
    logic            i_bready = 1'b1, i_rready = 1'b1;
    logic            o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
    logic [IDW-1:0]  o_bid, o_rid;
    logic [1:0]      o_bresp, o_rresp;
    logic [63:0]     o_rdata;

    axi_dma_ram #(.ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out or unexpected event (cycle %0d)", name, cyc);
    endtask

    // Behavioural model: memory as a word array, expected responses as queues.
    typedef struct { logic [63:0] data; logic last; logic [IDW-1:0] id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic [IDW-1:0] id; } bexp_t;
    logic [63:0] mem_m [DEPTH];
    rbeat_t      rexp[$];
    bexp_t       bexp[$];
    logic [63:0] rlog[$];
    int          wcyc_log[$];

    int w_base, w_beat, w_hs_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit w_fixed;
    int aw_cyc, ar_cyc, b_first_cyc, r_first_cyc = -1, r_last_cyc;
    logic [1:0] last_bresp;
    logic rv_p = 0, rr_p = 0, rl_p = 0, bv_p = 0;
    logic [63:0] rd_p = '0;

    always @(negedge clk) begin
        int idx;
        rbeat_t rb;
        bexp_t  be;
        if (rst_n) begin
            if (i_awvalid && o_awready) begin
                w_base  = int'(i_awaddr[31:3]) % DEPTH;
                w_fixed = (i_awburst == BURST_FIXED);
                w_beat  = 0;
                aw_cyc  = cyc;
            end
            if (i_wvalid && o_wready) begin
                idx = w_fixed ? w_base : (w_base + w_beat) % DEPTH;
                for (int b = 0; b < 8; b++)
                    if (i_wstrb[b]) mem_m[idx][8*b +: 8] = i_wdata[8*b +: 8];
                w_beat++;
                w_hs_cnt++;
                wcyc_log.push_back(cyc);
            end
            if (o_bvalid && !bv_p) b_first_cyc = cyc;
            if (o_bvalid && i_bready) begin
                if (bexp.size() == 0) fail_now("b_unexpected");
                else begin
                    be = bexp.pop_front();
                    chk("bresp", {62'h0, o_bresp}, {62'h0, be.resp});
                    chk("bid", {62'h0, o_bid}, {62'h0, be.id});
                end
                last_bresp = o_bresp;
                b_cnt++;
            end
            if (i_arvalid && o_arready) begin
                idx = int'(i_araddr[31:3]) % DEPTH;
                for (int i = 0; i <= int'(i_arlen); i++) begin
                    rexp.push_back('{mem_m[idx], (i == int'(i_arlen)), i_arid});
                    if (i_arburst != BURST_FIXED) idx = (idx + 1) % DEPTH;
                end
                ar_cyc      = cyc;
                r_first_cyc = -1;
            end
            if (o_rvalid && r_first_cyc < 0) r_first_cyc = cyc;
            if (rv_p && !rr_p) begin
                chk("r_hold_valid", {63'h0, o_rvalid}, 64'h1);
                chk("r_hold_data", o_rdata, rd_p);
                chk("r_hold_last", {63'h0, o_rlast}, {63'h0, rl_p});
            end
            if (o_rvalid && i_rready) begin
                if (rexp.size() == 0) fail_now("r_unexpected");
                else begin
                    rb = rexp.pop_front();
                    chk("rdata", o_rdata, rb.data);
                    chk("rlast", {63'h0, o_rlast}, {63'h0, rb.last});
                    chk("rid", {62'h0, o_rid}, {62'h0, rb.id});
                    chk("rresp", {62'h0, o_rresp}, 64'h0);
                end
                rlog.push_back(o_rdata);
                if (o_rlast) begin
                    r_last_cyc = cyc;
                    r_cnt++;
                end
            end
            rv_p = o_rvalid; rr_p = i_rready; rd_p = o_rdata; rl_p = o_rlast; bv_p = o_bvalid;
        end else begin
            rv_p = 0; rr_p = 0; bv_p = 0;
        end
    end

    // Ready drivers: 0 = held high, 1 = random, 2 = toggle every cycle.
    int rr_mode = 0, br_mode = 0;
    bit gap_en = 0;
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: i_rready = 1'b1;
            1: i_rready = 1'($urandom_range(0, 1));
            default: i_rready = ~i_rready;
        endcase
        i_bready = (br_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    logic [63:0] wd_q[$];
    logic [7:0]  ws_q[$];
    bit          wl_q[$];

    task automatic wr(input logic [31:0] addr, input int len, input logic [1:0] burst,
                      input logic [IDW-1:0] id);
        bit err = 0;
        int t;
        int b0 = b_cnt;
        for (int i = 0; i <= len; i++) if (wl_q[i] != (i == len)) err = 1;
        bexp.push_back('{err ? RESP_SLVERR : RESP_OKAY, id});
        @(posedge clk); #1;
        i_awaddr = addr; i_awlen = len[7:0]; i_awburst = burst; i_awid = id; i_awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!o_awready && t < 5000) begin t++; @(negedge clk); end
        if (t >= 5000) fail_now("aw_timeout");
        @(posedge clk); #1 i_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gap_en && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            i_wdata = wd_q[i]; i_wstrb = ws_q[i]; i_wlast = wl_q[i]; i_wvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!o_wready && t < 5000) begin t++; @(negedge clk); end
            if (t >= 5000) fail_now("w_timeout");
            @(posedge clk); #1 i_wvalid = 1'b0;
        end
        t = 0;
        while (b_cnt == b0 && t < 5000) begin t++; @(negedge clk); end
        if (t >= 5000) fail_now("b_timeout");
        wd_q.delete(); ws_q.delete(); wl_q.delete();
    endtask

    task automatic rd(input logic [31:0] addr, input int len, input logic [1:0] burst,
                      input logic [IDW-1:0] id);
        int t;
        int r0 = r_cnt;
        @(posedge clk); #1;
        i_araddr = addr; i_arlen = len[7:0]; i_arburst = burst; i_arid = id; i_arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!o_arready && t < 5000) begin t++; @(negedge clk); end
        if (t >= 5000) fail_now("ar_timeout");
        @(posedge clk); #1 i_arvalid = 1'b0;
        t = 0;
        while (r_cnt == r0 && t < 5000) begin t++; @(negedge clk); end
        if (t >= 5000) fail_now("r_timeout");
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] s, input bit l);
        wd_q.push_back(d); ws_q.push_back(s); wl_q.push_back(l);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, t, w0;
        #3;
        chk("rst_awready", {63'h0, o_awready}, 64'h0);
        chk("rst_arready", {63'h0, o_arready}, 64'h0);
        chk("rst_wready", {63'h0, o_wready}, 64'h0);
        chk("rst_bvalid", {63'h0, o_bvalid}, 64'h0);
        chk("rst_rvalid", {63'h0, o_rvalid}, 64'h0);
        chk("rst_rlast", {63'h0, o_rlast}, 64'h0);
        chk("rst_bid_rid", {60'h0, o_bid, o_rid}, 64'h0);
        chk("rst_resp", {60'h0, o_bresp, o_rresp}, 64'h0);
        chk("rst_rdata", o_rdata, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill the whole array so every later read has a known model value.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) push_beat({$urandom, $urandom}, 8'hFF, i == 255);
            wr((32'($urandom) << 13) | 32'(k * 2048), 255, BURST_INCR, 0);
        end

        // Single beat with latency checks.
        push_beat(64'h1122334455667788, 8'hFF, 1);
        wr(32'h100, 0, BURST_INCR, 1);
        chk("t1_b_latency", 64'(b_first_cyc - aw_cyc), 64'd2);
        chk("t1_bresp", {62'h0, last_bresp}, 64'h0);
        chk("t1_model", mem_m[32], 64'h1122334455667788);
        rlog.delete();
        rd(32'h100, 0, BURST_INCR, 2);
        chk("t1_r_latency", 64'(r_first_cyc - ar_cyc), 64'd2);
        chk("t1_rdata", rlog[0], 64'h1122334455667788);

        // INCR burst read back with rready toggling.
        for (int i = 0; i < 4; i++) push_beat(64'(i + 1), 8'hFF, i == 3);
        wr(32'h200, 3, BURST_INCR, 0);
        rr_mode = 2;
        rlog.delete();
        rd(32'h200, 3, BURST_INCR, 3);
        rr_mode = 0;
        chk("t2_beats", 64'(rlog.size()), 64'd4);
        for (int i = 0; i < 4 && i < rlog.size(); i++) chk("t2_data", rlog[i], 64'(i + 1));

        // FIXED burst: last beat only writes the low four bytes.
        push_beat(64'hA1A2A3A4A5A6A7A8, 8'hFF, 0);
        push_beat(64'hB1B2B3B4B5B6B7B8, 8'hFF, 0);
        push_beat(64'hC1C2C3C4C5C6C7C8, 8'h0F, 1);
        wr(32'h40, 2, BURST_FIXED, 2);
        chk("t3_model", mem_m[8], 64'hB1B2B3B4C5C6C7C8);
        rlog.delete();
        rd(32'h40, 0, BURST_INCR, 0);
        chk("t3_rdata", rlog[0], 64'hB1B2B3B4C5C6C7C8);

        // Concurrent 4-beat write and read: SRAM grants must alternate.
        for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, 8'hFF, i == 3);
        wcyc_log.delete();
        fork
            wr(32'h800, 3, BURST_INCR, 1);
            rd(32'h1000, 3, BURST_INCR, 2);
        join
        chk("t4_same_accept", 64'(aw_cyc - ar_cyc), 64'd0);
        chk("t4_w_first", 64'(wcyc_log[0] - aw_cyc), 64'd1);
        for (int i = 1; i < 4; i++) chk("t4_w_spacing", 64'(wcyc_log[i] - wcyc_log[i-1]), 64'd2);
        chk("t4_b_within", 64'((b_first_cyc - aw_cyc - 1) <= 9), 64'd1);
        chk("t4_r_within", 64'((r_last_cyc - ar_cyc - 1) <= 9), 64'd1);

        // Early wlast: both beats consumed, SLVERR; then a clean write gives OKAY.
        push_beat(64'h5555, 8'hFF, 1);
        push_beat(64'h6666, 8'hFF, 1);
        w0 = w_hs_cnt;
        wr(32'h300, 1, BURST_INCR, 3);
        chk("t5_beats", 64'(w_hs_cnt - w0), 64'd2);
        chk("t5_bresp_err", {62'h0, last_bresp}, 64'h2);
        push_beat(64'h7777, 8'hFF, 0);
        push_beat(64'h8888, 8'hFF, 1);
        wr(32'h300, 1, BURST_INCR, 3);
        chk("t5_bresp_ok", {62'h0, last_bresp}, 64'h0);

        // Reset during an 8-beat read.
        rlog.delete();
        @(posedge clk); #1;
        i_araddr = 32'h400; i_arlen = 8'd7; i_arburst = BURST_INCR; i_arid = 1; i_arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!o_arready && t < 100) begin t++; @(negedge clk); end
        @(posedge clk); #1 i_arvalid = 1'b0;
        t = 0;
        while (rlog.size() < 1 && t < 100) begin t++; @(negedge clk); end
        if (t >= 100) fail_now("t6_no_beat");
        @(posedge clk); #1;
        chk("t6_rvalid_pre", {63'h0, o_rvalid}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rvalid_rst", {63'h0, o_rvalid}, 64'h0);
        chk("t6_arready_rst", {63'h0, o_arready}, 64'h0);
        chk("t6_awready_rst", {63'h0, o_awready}, 64'h0);
        rexp.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_arready_after", {63'h0, o_arready}, 64'h1);
        rlog.delete();
        rd(32'h200, 3, BURST_INCR, 1);
        chk("t6_beats", 64'(rlog.size()), 64'd4);
        for (int i = 0; i < 4 && i < rlog.size(); i++) chk("t6_data", rlog[i], 64'(i + 1));

        // Randomised writes then reads, with stalls on every channel.
        gap_en = 1; rr_mode = 1; br_mode = 1;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++)
                push_beat({$urandom, $urandom}, 8'($urandom), i == len);
            if ($urandom_range(0, 5) == 0) begin
                t = $urandom_range(0, len);
                wl_q[t] = ~wl_q[t];
            end
            wr($urandom, len, 2'($urandom_range(0, 2)), IDW'($urandom));
        end
        for (int n = 0; n < 40; n++)
            rd($urandom, $urandom_range(0, 15), 2'($urandom_range(0, 2)), IDW'($urandom));
        chk("rexp_drained", 64'(rexp.size()), 64'd0);
        chk("bexp_drained", 64'(bexp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
